// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: shares the register-file write port between the pipeline
// writeback stage and out-of-band multiply/divide results. MCU results wait
// in a 2-entry FIFO and drain into idle writeback slots. A starvation counter
// forces a one-cycle pipeline stall so that queued results always retire.
// Optional feature macro: WB_ARB_BYPASS_EN. When it is defined, an MCU result
// is written in the same cycle if the port would otherwise be idle.
//
// grant   | meaning
// --------+--------------------------------------------------
// IDLE    | nothing written this cycle
// WB      | pipeline writeback request owns the port
// FIFO    | queued MCU result at the head is written and popped
// BYPASS  | MCU result written directly and never queued
module wb_write_arbiter #(
  parameter int DATA_WIDTH    = 16,
  parameter int REGADDR_WIDTH = 4,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wb_reg_write,
  input  logic [REGADDR_WIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0]    wb_data,
  input  logic                     mcu_valid,
  output logic                     mcu_ready,
  input  logic [REGADDR_WIDTH-1:0] mcu_rd,
  input  logic [DATA_WIDTH-1:0]    mcu_data,
  output logic                     rf_we,
  output logic [REGADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]    rf_wdata,
  output logic                     pipe_stall,
  output logic                     mcu_pending
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {GNT_IDLE, GNT_WB, GNT_FIFO, GNT_BYPASS} grant_e;

  logic [REGADDR_WIDTH-1:0] fifo_rd   [2];
  logic [DATA_WIDTH-1:0]    fifo_data [2];
  logic                     head;
  logic                     tail;
  logic [1:0]               count;
  logic [CNT_W-1:0]         starve_cnt;
  grant_e                   grant;
  logic                     wb_live;
  logic                     fifo_nonempty;
  logic                     bypass_ok;
  logic                     push;
  logic                     pop;

  assign wb_live       = wb_reg_write && (wb_rd != '0);
  assign fifo_nonempty = (count != 2'd0);
  assign mcu_ready     = (count != 2'd2);
  assign mcu_pending   = fifo_nonempty;

`ifdef WB_ARB_BYPASS_EN
  assign bypass_ok = !fifo_nonempty && !wb_live && !pipe_stall && mcu_valid && (mcu_rd != '0);
`else
  assign bypass_ok = 1'b0;
`endif

  // Grant selection and register-file port mux; reset forces the port idle
  // immediately since the pipeline inputs may still look live.
  always_comb begin
    grant    = GNT_IDLE;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (!reset_n)                         grant = GNT_IDLE;
    else if (pipe_stall && fifo_nonempty) grant = GNT_FIFO;
    else if (wb_live)                     grant = GNT_WB;
    else if (fifo_nonempty)               grant = GNT_FIFO;
    else if (bypass_ok)                   grant = GNT_BYPASS;
    case (grant)
      GNT_WB: begin
        rf_we    = 1'b1;
        rf_waddr = wb_rd;
        rf_wdata = wb_data;
      end
      GNT_FIFO: begin
        rf_we    = 1'b1;
        rf_waddr = fifo_rd[head];
        rf_wdata = fifo_data[head];
      end
      GNT_BYPASS: begin
        rf_we    = 1'b1;
        rf_waddr = mcu_rd;
        rf_wdata = mcu_data;
      end
      default: ;
    endcase
  end

  // rd=0 results are accepted by the handshake but never stored.
  assign push = mcu_valid && mcu_ready && (mcu_rd != '0) && (grant != GNT_BYPASS);
  assign pop  = (grant == GNT_FIFO);

  // FIFO pointers, occupancy and storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head      <= 1'b0;
      tail      <= 1'b0;
      count     <= 2'd0;
      fifo_rd   <= '{default: '0};
      fifo_data <= '{default: '0};
    end else begin
      if (push) begin
        fifo_rd[tail]   <= mcu_rd;
        fifo_data[tail] <= mcu_data;
        tail            <= ~tail;
      end
      if (pop) head <= ~head;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Starvation timer: a one-cycle stall fires when the queued head has been
  // passed over STARVE_LIMIT cycles in a row; the stall grant clears it again.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
      pipe_stall <= 1'b0;
    end else if (!fifo_nonempty || pop) begin
      starve_cnt <= '0;
      pipe_stall <= 1'b0;
    end else if (starve_cnt == CNT_W'(STARVE_LIMIT - 1)) begin
      starve_cnt <= '0;
      pipe_stall <= 1'b1;
    end else begin
      starve_cnt <= starve_cnt + 1'b1;
      pipe_stall <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Testbench for wb_write_arbiter: directed scenarios followed by random
// traffic, each cycle compared against a queue-based reference model.
module tb_wb_write_arbiter;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int SL = 4;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          wb_reg_write = 1'b0;
  logic [AW-1:0] wb_rd = '0;
  logic [DW-1:0] wb_data = '0;
  logic          mcu_valid = 1'b0;
  logic          mcu_ready;
  logic [AW-1:0] mcu_rd = '0;
  logic [DW-1:0] mcu_data = '0;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          pipe_stall;
  logic          mcu_pending;

  wb_write_arbiter #(.DATA_WIDTH(DW), .REGADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset_n(reset_n),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .mcu_valid(mcu_valid), .mcu_ready(mcu_ready), .mcu_rd(mcu_rd), .mcu_data(mcu_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pipe_stall(pipe_stall), .mcu_pending(mcu_pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  ent_t q[$];
  int   m_cnt = 0;
  bit   m_stall = 1'b0;
  bit   last_stall = 1'b0;
  bit   prev_stall_obs = 1'b0;
  // expected outputs for the current cycle; e_gnt: 0 idle, 1 wb, 2 queue, 3 bypass
  bit            e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  int            e_gnt;
  bit            e_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_eval();
    bit live;
    bit byp;
    live = wb_reg_write && (wb_rd != 0);
    byp  = 1'b0;
    e_ready = (q.size() < 2);
`ifdef WB_ARB_BYPASS_EN
    byp = (q.size() == 0) && !live && !m_stall && mcu_valid && (mcu_rd != 0);
`endif
    e_gnt = 0;
    if (m_stall && q.size() > 0) e_gnt = 2;
    else if (live)               e_gnt = 1;
    else if (q.size() > 0)       e_gnt = 2;
    else if (byp)                e_gnt = 3;
    e_we = 1'b0; e_addr = '0; e_data = '0;
    case (e_gnt)
      1: begin e_we = 1'b1; e_addr = wb_rd;   e_data = wb_data;   end
      2: begin e_we = 1'b1; e_addr = q[0].rd; e_data = q[0].data; end
      3: begin e_we = 1'b1; e_addr = mcu_rd;  e_data = mcu_data;  end
      default: ;
    endcase
  endtask

  task automatic model_advance();
    bit   had_entry;
    bit   popped;
    ent_t e;
    had_entry = (q.size() > 0);
    popped    = (e_gnt == 2);
    if (popped) void'(q.pop_front());
    if (mcu_valid && e_ready && mcu_rd != 0 && e_gnt != 3) begin
      e.rd = mcu_rd; e.data = mcu_data;
      q.push_back(e);
    end
    last_stall = m_stall;
    if (!had_entry || popped) begin
      m_cnt = 0; m_stall = 1'b0;
    end else if (m_cnt + 1 == SL) begin
      m_cnt = 0; m_stall = 1'b1;
    end else begin
      m_cnt++; m_stall = 1'b0;
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_cnt = 0; m_stall = 1'b0; last_stall = 1'b0; prev_stall_obs = 1'b0;
  endtask

  // called shortly after a rising edge: let inputs settle, compare outputs
  task automatic observe();
    #2;
    model_eval();
    chk("rf_we", rf_we, e_we);
    chk("rf_waddr", rf_waddr, e_addr);
    chk("rf_wdata", rf_wdata, e_data);
    chk("mcu_ready", mcu_ready, e_ready);
    chk("mcu_pending", mcu_pending, q.size() != 0);
    chk("pipe_stall", pipe_stall, m_stall);
    chk("stall_back_to_back", prev_stall_obs && pipe_stall, 1'b0);
    prev_stall_obs = pipe_stall;
  endtask

  task automatic advance();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic w, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    wb_reg_write = w; wb_rd = rd; wb_data = d;
  endtask

  task automatic set_mcu(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    mcu_valid = v; mcu_rd = rd; mcu_data = d;
  endtask

  initial begin
    int acc[3];
    int idx;
    bit accepted;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rf_we", rf_we, 1'b0);
    chk("reset_ready", mcu_ready, 1'b1);
    chk("reset_pending", mcu_pending, 1'b0);
    chk("reset_stall", pipe_stall, 1'b0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // WB only, then rd=0 dropped
    set_wb(1'b1, 4'd5, 16'h1234);
    observe();
    chk("wb_we", rf_we, 1'b1);
    chk("wb_addr", rf_waddr, 4'd5);
    chk("wb_data", rf_wdata, 16'h1234);
    advance();
    set_wb(1'b1, 4'd0, 16'h4321);
    observe();
    chk("wb_rd0_we", rf_we, 1'b0);
    advance();
    set_wb(1'b0, 4'd0, 16'h0);

`ifndef WB_ARB_BYPASS_EN
    // MCU drain through the FIFO
    set_mcu(1'b1, 4'd3, 16'h00AA);
    observe();
    chk("drain_no_same_cycle", rf_we, 1'b0);
    advance();
    set_mcu(1'b0, 4'd0, 16'h0);
    observe();
    chk("drain_addr", rf_waddr, 4'd3);
    chk("drain_data", rf_wdata, 16'h00AA);
    advance();
    observe();
    chk("drain_pending_clear", mcu_pending, 1'b0);
    advance();
`else
    // same-cycle bypass
    set_mcu(1'b1, 4'd7, 16'hBEEF);
    observe();
    chk("bypass_we", rf_we, 1'b1);
    chk("bypass_addr", rf_waddr, 4'd7);
    chk("bypass_data", rf_wdata, 16'hBEEF);
    chk("bypass_pending", mcu_pending, 1'b0);
    advance();
    set_mcu(1'b0, 4'd0, 16'h0);
    observe();
    chk("bypass_pending_after", mcu_pending, 1'b0);
    advance();
`endif

    // starvation: one queued result under continuous live WB writes
    for (int k = 0; k < 8; k++) begin
      if (!last_stall) set_wb(1'b1, AW'((k % 7) + 1), DW'(16'h1000 + k));
      if (k == 0) set_mcu(1'b1, 4'd3, 16'h0055);
      else        set_mcu(1'b0, 4'd0, 16'h0);
      observe();
      chk("starve_stall", pipe_stall, k == 5);
      if (k == 5) begin
        chk("starve_mcu_addr", rf_waddr, 4'd3);
        chk("starve_mcu_data", rf_wdata, 16'h0055);
      end
      if (k == 6) chk("starve_wb_replay", rf_wdata, 16'h1005);
      advance();
    end

    // backpressure: three results back-to-back with WB always live
    idx = 0;
    for (int k = 0; k < 9; k++) begin
      if (!last_stall) set_wb(1'b1, 4'd2, DW'(16'h2000 + k));
      if (idx < 3) set_mcu(1'b1, AW'(8 + idx), DW'(16'h00A0 + idx));
      else         set_mcu(1'b0, 4'd0, 16'h0);
      observe();
      if (k == 2) chk("bp_ready_low", mcu_ready, 1'b0);
      if (mcu_valid && e_ready && idx < 3) begin
        acc[idx] = k;
        idx++;
      end
      advance();
    end
    chk("bp_accept0", acc[0], 0);
    chk("bp_accept1", acc[1], 1);
    chk("bp_accept2", acc[2], 6);

    // reset mid-traffic with two queued results
    chk("pre_reset_pending", mcu_pending, 1'b1);
    set_mcu(1'b1, 4'd9, 16'h0BAD);
    reset_n = 1'b0;
    #1;
    chk("midreset_rf_we", rf_we, 1'b0);
    chk("midreset_pending", mcu_pending, 1'b0);
    chk("midreset_ready", mcu_ready, 1'b1);
    model_reset();
    set_wb(1'b0, 4'd0, 16'h0);
    set_mcu(1'b0, 4'd0, 16'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      observe();
      chk("post_reset_no_write", rf_we, 1'b0);
      advance();
    end

    // random traffic: dense WB phase, then sparse WB phase
    accepted = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!last_stall) begin
        if (i < 300) wb_reg_write = ($urandom_range(0, 7) != 0);
        else         wb_reg_write = ($urandom_range(0, 3) == 0);
        wb_rd   = AW'($urandom);
        wb_data = DW'($urandom);
      end
      if (!mcu_valid || accepted) begin
        if ($urandom_range(0, 2) == 0) set_mcu(1'b1, AW'($urandom), DW'($urandom));
        else                           set_mcu(1'b0, 4'd0, 16'h0);
      end
      observe();
      accepted = mcu_valid && e_ready;
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Shares the single register-file write port between the pipeline writeback stage and a multi-cycle unit (MCU: multiply/divide) that completes out of band. MCU results are queued in a 2-entry FIFO and drained into idle writeback slots. A starvation counter forces a one-cycle pipeline stall so that queued results always retire. The block sits between the MEM/WB register outputs, the MCU result port and the register file write port.

## Interface
- DATA_WIDTH, 16, register/data width
- REGADDR_WIDTH, 4, register address width
- STARVE_LIMIT, 4, consecutive non-granted cycles with FIFO non-empty before a forced stall (≥1)

- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- wb_reg_write  in  1  pipeline WB write request
- wb_rd  in  REGADDR_WIDTH  pipeline WB destination
- wb_data  in  DATA_WIDTH  pipeline WB data (already muxed ALU/load/link)
- mcu_valid  in  1  MCU result valid
- mcu_ready  out  1  FIFO can accept a result
- mcu_rd  in  REGADDR_WIDTH  MCU destination
- mcu_data  in  DATA_WIDTH  MCU result
- rf_we  out  1  register-file write enable
- rf_waddr  out  REGADDR_WIDTH  register-file write address
- rf_wdata  out  DATA_WIDTH  register-file write data
- pipe_stall  out  1  registered; freezes MEM/WB and upstream for one cycle
- mcu_pending  out  1  FIFO non-empty

## Operation
- A WB request is live when wb_reg_write=1 and wb_rd≠0; rd=0 requests are dropped (rf_we=0).
- FIFO: depth 2, head/tail pointers plus 2-bit count. Push on mcu_valid && mcu_ready. mcu_ready = (count<2). MCU results with mcu_rd=0 are accepted and discarded, never pushed.
- Grant priority per cycle:
  - pipe_stall=1: grant the FIFO head, ignore WB inputs.
  - Otherwise a live WB request wins.
  - Otherwise the FIFO head, if non-empty.
  - Otherwise idle.
- A granted head pops in the same cycle. Push and pop in one cycle are both allowed, so count is unchanged.
- rf_* are combinational from the grant. When idle, rf_we=0, rf_waddr=0, rf_wdata=0.
- Starvation counter, width $clog2(STARVE_LIMIT+1):
  - Increments each cycle the FIFO is non-empty and the head is not granted.
  - Clears on any FIFO grant, or when the FIFO is empty.
  - When it would reach STARVE_LIMIT, pipe_stall is set for the next cycle only, and the counter clears.
- Pipeline contract: while pipe_stall=1, MEM/WB holds its contents, so the same WB request is re-presented the following cycle.

## Timing
- Reset (reset_n=0, asynchronous): FIFO empty, counter 0, pipe_stall=0, mcu_ready=1, mcu_pending=0, and rf_we forced 0.
- WB path: zero latency (combinational to rf_*).
- MCU path: written no earlier than the cycle after acceptance. Worst case is STARVE_LIMIT+1 cycles after reaching the head.
- pipe_stall is never asserted in two consecutive cycles.
- Reset mid-operation discards queued MCU results. Because the MCU must also be reset, pending results are lost by design.
- Full FIFO: mcu_ready=0 the cycle after the second push. The MCU holds mcu_valid/data stable until it sees ready.

## Configuration
- WB_ARB_BYPASS_EN defined: if the FIFO is empty, no live WB request is present, pipe_stall=0 and mcu_valid=1 with mcu_rd≠0, the MCU result is written the same cycle and not pushed.
- WB_ARB_BYPASS_EN undefined: every MCU result passes through the FIFO, with a minimum latency of 1 cycle.

## Test plan
- Reset: assert reset_n=0 mid-traffic with the FIFO holding 2 → immediately rf_we=0, mcu_pending=0, mcu_ready=1. After release, no stale write occurs.
- WB only: wb_reg_write=1, wb_rd=5, wb_data=0x1234 → same cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234. Repeat with wb_rd=0 → rf_we=0.
- MCU drain: push rd=3 data=0x00AA with WB idle (bypass off) → next cycle rf_waddr=3, rf_wdata=0x00AA, then mcu_pending=0.
- Starvation: STARVE_LIMIT=4, one queued MCU result, continuous live WB writes → pipe_stall=1 in the 5th cycle after the push, and the MCU result is written that cycle. WB data is not written that cycle and is written the next.
- Backpressure: push 3 MCU results back-to-back with WB always live → mcu_ready=0 after 2 pushes. The third is accepted only after the stall-forced pop.
- Bypass (macro on): FIFO empty, WB idle, mcu_valid with rd=7, data=0xBEEF → same-cycle write, and mcu_pending stays 0.
